uart_mem_loader: RTL and testbench

Serial program loader that sits directly upstream of the system memory's write port. It receives a framed binary image over a UART line, writes it byte-by-byte into memory through the memory's write_enable/ADDRESS/DATA_IN port, and holds the 6502 core off the bus while loading. This lets a new program be downloaded without rebuilding the memory initialisation file.

---
 rtl/uart_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Serial program loader placed in front of the system memory's write port.
//   It receives a framed binary image over an 8N1 UART line and writes it
//   byte-by-byte into memory. While a frame is in progress it holds the 6502
//   core off the bus.
//
//   Frame: 0x4C, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes
//          [, CHK byte when LOADER_CHECKSUM_EN is defined]
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing checksum byte is expected. The 8-bit sum of
//     ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, all data bytes and CHK must be 0x00.
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BAUD          UART bit rate; CLK_HZ/BAUD must be >= 4
//   TIMEOUT_BITS  idle bit-times allowed between bytes inside a frame
//
// Ports
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   uart_rx           serial input, idle high, LSB first
//   mem_write_enable  one-cycle write strobe per data byte
//   mem_address       15-bit write address (holds between writes)
//   mem_data_out      write data (holds between writes)
//   cpu_hold          high while a frame is in progress
//   done              one-cycle pulse on successful frame completion
//   error             sticky error flag, cleared by the next 0x4C header
module uart_mem_loader #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        mem_write_enable,
  output logic [14:0] mem_address,
  output logic [7:0]  mem_data_out,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int DIV     = CLK_HZ / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int CW      = $clog2(DIV);
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CLKS - 1);

  // ---------------------------------------------------------------------
  // Input synchroniser plus one extra stage for falling-edge detection.
  // Reset to the idle line level so reset release is not seen as a start.
  // ---------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------
  // UART byte receiver. rx_valid / rx_ferr pulse for one cycle after the
  // stop-bit sample; the received byte stays in rx_shift until the next
  // byte's first data sample, long after the loader has consumed it.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_valid;
  logic            rx_ferr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit recheck: a line back high means it was a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame loader FSM. L_FIN exists only to delay the done pulse one clock
  // past the final write strobe.
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_IDLE, L_AHI, L_ALO, L_LHI, L_LLO, L_DATA, L_CHK, L_FIN
  } ld_state_t;

  ld_state_t     ld_state;
  logic [14:0]   addr;
  logic [15:0]   count;
  logic [TW-1:0] idle_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state         <= L_IDLE;
      addr             <= '0;
      count            <= '0;
      idle_cnt         <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_out     <= '0;
      cpu_hold         <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      mem_write_enable <= 1'b0;
      done             <= 1'b0;

      // Inter-byte timeout counts only while a frame is open and the
      // receiver is waiting for a start bit.
      if (ld_state == L_IDLE || rx_state != RX_IDLE) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (rx_ferr) begin
        error    <= 1'b1;
        cpu_hold <= 1'b0;
        ld_state <= L_IDLE;
      end else if (ld_state == L_FIN) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
        ld_state <= L_IDLE;
      end else if (rx_valid) begin
        case (ld_state)
          L_IDLE: begin
            if (rx_shift == 8'h4C) begin
              error    <= 1'b0;
              cpu_hold <= 1'b1;
              ld_state <= L_AHI;
`ifdef LOADER_CHECKSUM_EN
              sum      <= '0;
`endif
            end
          end
          L_AHI: begin
            // Address bit 15 is dropped: memory space is 32 KiB.
            addr[14:8] <= rx_shift[6:0];
            ld_state   <= L_ALO;
`ifdef LOADER_CHECKSUM_EN
            sum        <= sum + rx_shift;
`endif
          end
          L_ALO: begin
            addr[7:0] <= rx_shift;
            ld_state  <= L_LHI;
`ifdef LOADER_CHECKSUM_EN
            sum       <= sum + rx_shift;
`endif
          end
          L_LHI: begin
            count[15:8] <= rx_shift;
            ld_state    <= L_LLO;
`ifdef LOADER_CHECKSUM_EN
            sum         <= sum + rx_shift;
`endif
          end
          L_LLO: begin
            count[7:0] <= rx_shift;
`ifdef LOADER_CHECKSUM_EN
            sum        <= sum + rx_shift;
`endif
            if ({count[15:8], rx_shift} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              ld_state <= L_CHK;
`else
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              ld_state <= L_IDLE;
`endif
            end else begin
              ld_state <= L_DATA;
            end
          end
          L_DATA: begin
            mem_write_enable <= 1'b1;
            mem_address      <= addr;
            mem_data_out     <= rx_shift;
            addr             <= addr + 15'd1;  // natural wrap 0x7FFF -> 0x0000
            count            <= count - 16'd1;
`ifdef LOADER_CHECKSUM_EN
            sum              <= sum + rx_shift;
`endif
            if (count == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              ld_state <= L_CHK;
`else
              ld_state <= L_FIN;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          L_CHK: begin
            cpu_hold <= 1'b0;
            ld_state <= L_IDLE;
            if (sum + rx_shift == 8'h00) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
`endif
          default: ld_state <= L_IDLE;
        endcase
      end else if (ld_state != L_IDLE && idle_cnt == TO_LAST) begin
        error    <= 1'b1;
        cpu_hold <= 1'b0;
        ld_state <= L_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader at DIV = 10 (1 MHz clock, 100 kbaud).
// Frames come from a table; expected memory writes are queued when a frame
// is sent and popped by a monitor as the DUT strobes mem_write_enable.
module tb_uart_mem_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mem_write_enable;
  logic [14:0] mem_address;
  logic [7:0]  mem_data_out;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .TIMEOUT_BITS(255)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart_rx(uart_rx),
    .mem_write_enable(mem_write_enable),
    .mem_address(mem_address),
    .mem_data_out(mem_data_out),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  typedef struct {
    int                nb;
    logic [0:11][7:0]  b;
    int                hold_from;  // index of the 0x4C header byte
    logic [7:0]        chk;        // used only with the checksum build
    int                nw;
    logic [0:3][14:0]  wa;
    logic [0:3][7:0]   wd;
    int                exp_done;
    logic              exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  bit          we_pending = 1'b0;
  logic        prev_we = 1'b0;
  logic [22:0] exp_q[$];

  vec_t vecs[6];
  int   nv;
  vec_t vr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [22:0] e;
    cyc++;
    if (reset_n) begin
      if (mem_write_enable) begin
        check("we_single_cycle", {31'b0, prev_we}, 32'd0);
        check("write_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", {17'b0, mem_address}, {17'b0, e[22:8]});
          check("wr_data", {24'b0, mem_data_out}, {24'b0, e[7:0]});
        end
        last_we_cyc = cyc;
        we_pending  = 1'b1;
      end
      if (done) begin
        done_cnt++;
        check("hold_drops_with_done", {31'b0, cpu_hold}, 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (we_pending) check("done_after_last_write", cyc - last_we_cyc, 32'd1);
`endif
        we_pending = 1'b0;
      end
      prev_we = mem_write_enable;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (DIV) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'b0, mem_write_enable}, 32'd0);
    check({tag, "_addr"},  {17'b0, mem_address}, 32'd0);
    check({tag, "_data"},  {24'b0, mem_data_out}, 32'd0);
    check({tag, "_hold"},  {31'b0, cpu_hold}, 32'd0);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int hold_limit;
    done_cnt   = 0;
    we_pending = 1'b0;
    hold_limit = v.nb - 1;  // last byte may already have finished the frame
`ifdef LOADER_CHECKSUM_EN
    hold_limit = v.nb;
`endif
    for (int w = 0; w < v.nw; w++) exp_q.push_back({v.wa[w], v.wd[w]});
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.b[i], 1'b1);
      if (i == v.hold_from) check("error_cleared_by_header", {31'b0, error}, 32'd0);
      if (i < hold_limit) check("cpu_hold_during_frame", {31'b0, cpu_hold}, {31'b0, i >= v.hold_from});
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(v.chk, 1'b1);
`endif
    repeat (3 * DIV) @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    check("done_count", done_cnt, v.exp_done);
    check("error_after_frame", {31'b0, error}, {31'b0, v.exp_err});
    check("cpu_hold_after_frame", {31'b0, cpu_hold}, 32'd0);
    $display("frame %0d: %0d bytes, %0d writes, done=%0d error=%0b", idx, v.nb, v.nw, done_cnt, error);
  endtask

  initial begin
    // ---- vector table ----
    vecs[0] = '{nb: 8, b: 96'h4C_02_00_00_03_AA_BB_CC_00_00_00_00, hold_from: 0, chk: 8'hCA,
                nw: 3, wa: {15'h0200, 15'h0201, 15'h0202, 15'h0000}, wd: 32'hAA_BB_CC_00,
                exp_done: 1, exp_err: 1'b0};
    vecs[1] = '{nb: 7, b: 96'h4C_7F_FF_00_02_11_22_00_00_00_00_00, hold_from: 0, chk: 8'h4D,
                nw: 2, wa: {15'h7FFF, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h11_22_00_00,
                exp_done: 1, exp_err: 1'b0};
    vecs[2] = '{nb: 7, b: 96'h00_FF_4C_01_00_00_00_00_00_00_00_00, hold_from: 2, chk: 8'hFF,
                nw: 0, wa: {15'h0000, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h0,
                exp_done: 1, exp_err: 1'b0};
    vecs[3] = '{nb: 6, b: 96'h4C_80_05_00_01_77_00_00_00_00_00_00, hold_from: 0, chk: 8'h03,
                nw: 1, wa: {15'h0005, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h77_00_00_00,
                exp_done: 1, exp_err: 1'b0};
    vecs[4] = '{nb: 6, b: 96'h4C_00_10_00_01_5A_00_00_00_00_00_00, hold_from: 0, chk: 8'h95,
                nw: 1, wa: {15'h0010, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h5A_00_00_00,
                exp_done: 1, exp_err: 1'b0};
    vecs[5] = '{nb: 6, b: 96'h4C_00_10_00_01_5A_00_00_00_00_00_00, hold_from: 0, chk: 8'h00,
                nw: 1, wa: {15'h0010, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h5A_00_00_00,
                exp_done: 0, exp_err: 1'b1};
    nv = 4;
`ifdef LOADER_CHECKSUM_EN
    nv = 6;
`endif
    vr = '{nb: 6, b: 96'h4C_00_20_00_01_5A_00_00_00_00_00_00, hold_from: 0, chk: 8'h85,
           nw: 1, wa: {15'h0020, 15'h0000, 15'h0000, 15'h0000}, wd: 32'h5A_00_00_00,
           exp_done: 1, exp_err: 1'b0};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check_reset_outputs("after_reset");

    // ---- table-driven frames ----
    for (int k = 0; k < nv; k++) run_vec(vecs[k], k);

    // ---- inter-byte timeout ----
    done_cnt = 0;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h01, 1'b1);
    check("hold_before_timeout", {31'b0, cpu_hold}, 32'd1);
    repeat (2500) @(negedge clk);
    check("hold_just_before_timeout", {31'b0, cpu_hold}, 32'd1);
    check("error_just_before_timeout", {31'b0, error}, 32'd0);
    repeat (100) @(negedge clk);
    check("timeout_error", {31'b0, error}, 32'd1);
    check("timeout_hold", {31'b0, cpu_hold}, 32'd0);
    check("timeout_no_done", done_cnt, 32'd0);
    $display("timeout: error=%0b cpu_hold=%0b", error, cpu_hold);
    run_vec(vr, 100);

    // ---- framing error mid-DATA ----
    done_cnt = 0;
    exp_q.push_back({15'h0300, 8'h33});
    send_byte(8'h4C, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check("ferr_error", {31'b0, error}, 32'd1);
    check("ferr_hold", {31'b0, cpu_hold}, 32'd0);
    check("ferr_no_done", done_cnt, 32'd0);
    check("ferr_writes", exp_q.size(), 32'd0);
    exp_q.delete();
    $display("framing error: error=%0b cpu_hold=%0b", error, cpu_hold);

    // ---- reset mid-frame ----
    exp_q.push_back({15'h0400, 8'h55});
    send_byte(8'h4C, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b1);
    check("hold_mid_frame", {31'b0, cpu_hold}, 32'd1);
    check("mid_frame_writes", exp_q.size(), 32'd0);
    uart_rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    $display("reset mid-frame: cpu_hold=%0b mem_address=%0h", cpu_hold, mem_address);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("post_reset_hold", {31'b0, cpu_hold}, 32'd0);
    run_vec(vecs[0], 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
